// File: rtl/adc_ltc2308_ctrl.sv
// LTC2308 serial master: one CONVST/shift/acquire frame per accepted request, results pipelined by one frame.
// Optional ADC_SCAN_EN adds i_scan_en for free-running channel 0..7 scanning.
module adc_ltc2308_ctrl #(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned CONV_CYCLES = 80,
    parameter int unsigned ACQ_CYCLES  = 12
) (
    input  logic        i_clk,
    input  logic        i_reset,
`ifdef ADC_SCAN_EN
    input  logic        i_scan_en,
`endif
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [2:0]  i_req_ch,
    input  logic        i_req_uni,
    output logic        o_res_valid,
    output logic [11:0] o_res_data,
    output logic [2:0]  o_res_ch,
    output logic        o_adc_convst,
    output logic        o_adc_sck,
    output logic        o_adc_sdi,
    input  logic        i_adc_sdo
);

    localparam int unsigned CntMax0 = (CONV_CYCLES > ACQ_CYCLES) ? CONV_CYCLES : ACQ_CYCLES;
    localparam int unsigned CntMax  = (CntMax0 > CLK_DIV) ? CntMax0 : CLK_DIV;
    localparam int unsigned CntW    = $clog2(CntMax + 1);

    typedef enum logic [1:0] {StIdle, StConv, StShift, StAcq} state_t;

    state_t          r_state, w_state_n;
    logic [CntW-1:0] r_cnt, w_cnt_n;
    logic [3:0]      r_bit, w_bit_n;
    logic [5:0]      r_cfg, w_cfg_n;
    logic [2:0]      r_cur_ch, w_cur_ch_n;
    logic [2:0]      r_prev_ch, w_prev_ch_n;
    logic            r_prev_ok, w_prev_ok_n;
    logic [11:0]     r_shift, w_shift_n;
    logic            r_convst, w_convst_n;
    logic            r_sck, w_sck_n;
    logic            r_sdi, w_sdi_n;
    logic            r_res_valid, w_res_valid_n;
    logic [11:0]     r_res_data, w_res_data_n;
    logic [2:0]      r_res_ch, w_res_ch_n;
    logic            w_start;
    logic [2:0]      w_ch;

`ifdef ADC_SCAN_EN
    logic       r_scan_q, r_scan_first, w_scan_first_n;
    logic [2:0] r_scan_ptr, w_scan_ptr_n;
    logic       w_scan_rise, w_first;
    logic [2:0] w_ptr_eff;

    assign w_scan_rise = i_scan_en & ~r_scan_q;
    assign w_first     = w_scan_rise | r_scan_first;
    assign w_ptr_eff   = w_scan_rise ? 3'd0 : r_scan_ptr;
    assign o_req_ready = (r_state == StIdle) && !i_scan_en;
    assign w_start     = (r_state == StIdle) && (i_scan_en || i_req_valid);
    assign w_ch        = i_scan_en ? w_ptr_eff : i_req_ch;
`else
    assign o_req_ready = (r_state == StIdle);
    assign w_start     = (r_state == StIdle) && i_req_valid;
    assign w_ch        = i_req_ch;
`endif

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_bit_n       = r_bit;
        w_cfg_n       = r_cfg;
        w_cur_ch_n    = r_cur_ch;
        w_prev_ch_n   = r_prev_ch;
        w_prev_ok_n   = r_prev_ok;
        w_shift_n     = r_shift;
        w_convst_n    = r_convst;
        w_sck_n       = r_sck;
        w_sdi_n       = r_sdi;
        w_res_valid_n = 1'b0;
        w_res_data_n  = r_res_data;
        w_res_ch_n    = r_res_ch;
`ifdef ADC_SCAN_EN
        w_scan_first_n = r_scan_first;
        w_scan_ptr_n   = r_scan_ptr;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_n  = StConv;
                    w_cnt_n    = CntW'(CONV_CYCLES - 1);
                    w_cfg_n    = {1'b1, w_ch[0], w_ch[2], w_ch[1], i_req_uni, 1'b0};
                    w_cur_ch_n = w_ch;
                    w_convst_n = 1'b1;
                end
            end
            StConv: begin
                if (r_cnt == '0) begin
                    w_state_n  = StShift;
                    w_convst_n = 1'b0;
                    w_sck_n    = 1'b0;
                    w_sdi_n    = r_cfg[5];
                    w_cfg_n    = {r_cfg[4:0], 1'b0};
                    w_bit_n    = 4'd0;
                    w_cnt_n    = CntW'(CLK_DIV - 1);
                end else begin
                    w_cnt_n = r_cnt - CntW'(1);
                end
            end
            StShift: begin
                if (r_cnt != '0) begin
                    w_cnt_n = r_cnt - CntW'(1);
                end else begin
                    w_cnt_n = CntW'(CLK_DIV - 1);
                    if (!r_sck) begin
                        w_sck_n   = 1'b1;
                        w_shift_n = {r_shift[10:0], i_adc_sdo};
                    end else begin
                        w_sck_n = 1'b0;
                        if (r_bit == 4'd11) begin
                            w_state_n     = StAcq;
                            w_cnt_n       = CntW'(ACQ_CYCLES - 1);
                            w_sdi_n       = 1'b0;
                            // This frame's data belongs to the previous frame's config.
                            w_res_valid_n = r_prev_ok;
                            if (r_prev_ok) begin
                                w_res_data_n = r_shift;
                                w_res_ch_n   = r_prev_ch;
                            end
                            w_prev_ch_n = r_cur_ch;
                            w_prev_ok_n = 1'b1;
                        end else begin
                            w_bit_n = r_bit + 4'd1;
                            w_sdi_n = r_cfg[5];
                            w_cfg_n = {r_cfg[4:0], 1'b0};
                        end
                    end
                end
            end
            StAcq: begin
                if (r_cnt == '0) begin
                    w_state_n = StIdle;
                end else begin
                    w_cnt_n = r_cnt - CntW'(1);
                end
            end
            default: w_state_n = StIdle;
        endcase
`ifdef ADC_SCAN_EN
        if (w_scan_rise) begin
            w_scan_first_n = 1'b1;
            w_scan_ptr_n   = 3'd0;
        end
        if (w_start && i_scan_en) begin
            w_scan_ptr_n   = w_ptr_eff + 3'd1;
            w_scan_first_n = 1'b0;
            if (w_first) w_prev_ok_n = 1'b0;
        end
`endif
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_bit       <= 4'd0;
            r_cfg       <= 6'd0;
            r_cur_ch    <= 3'd0;
            r_prev_ch   <= 3'd0;
            r_prev_ok   <= 1'b0;
            r_shift     <= 12'd0;
            r_convst    <= 1'b0;
            r_sck       <= 1'b0;
            r_sdi       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= 12'd0;
            r_res_ch    <= 3'd0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_bit       <= w_bit_n;
            r_cfg       <= w_cfg_n;
            r_cur_ch    <= w_cur_ch_n;
            r_prev_ch   <= w_prev_ch_n;
            r_prev_ok   <= w_prev_ok_n;
            r_shift     <= w_shift_n;
            r_convst    <= w_convst_n;
            r_sck       <= w_sck_n;
            r_sdi       <= w_sdi_n;
            r_res_valid <= w_res_valid_n;
            r_res_data  <= w_res_data_n;
            r_res_ch    <= w_res_ch_n;
        end
    end

`ifdef ADC_SCAN_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_scan_q     <= 1'b0;
            r_scan_first <= 1'b0;
            r_scan_ptr   <= 3'd0;
        end else begin
            r_scan_q     <= i_scan_en;
            r_scan_first <= w_scan_first_n;
            r_scan_ptr   <= w_scan_ptr_n;
        end
    end
`endif

    assign o_res_valid  = r_res_valid;
    assign o_res_data   = r_res_data;
    assign o_res_ch     = r_res_ch;
    assign o_adc_convst = r_convst;
    assign o_adc_sck    = r_sck;
    assign o_adc_sdi    = r_sdi;

endmodule

// File: tb/tb_adc_ltc2308_ctrl.sv
// Directed bench for adc_ltc2308_ctrl with a simple LTC2308 SPI model (CLK_DIV=2, CONV=80, ACQ=12).
module tb_adc_ltc2308_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_en = 1'b0;
    logic        req_valid, req_ready, req_uni;
    logic [2:0]  req_ch;
    logic        res_valid;
    logic [11:0] res_data;
    logic [2:0]  res_ch;
    logic        adc_convst, adc_sck, adc_sdi, adc_sdo;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adc_ltc2308_ctrl #(.CLK_DIV(2), .CONV_CYCLES(80), .ACQ_CYCLES(12)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
`ifdef ADC_SCAN_EN
        .i_scan_en    (scan_en),
`endif
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_ch     (req_ch),
        .i_req_uni    (req_uni),
        .o_res_valid  (res_valid),
        .o_res_data   (res_data),
        .o_res_ch     (res_ch),
        .o_adc_convst (adc_convst),
        .o_adc_sck    (adc_sck),
        .o_adc_sdi    (adc_sdi),
        .i_adc_sdo    (adc_sdo)
    );

    // ADC model: SDO presents model_word MSB first, advancing after each SCK rise.
    logic [11:0] model_word = 12'h000;
    logic [11:0] m_sh;
    logic [11:0] m_sdi_rx = 12'h000;
    int          m_rise = 0;

    always @(posedge adc_convst or posedge adc_sck) begin
        if (adc_convst) begin
            m_rise   <= 0;
            m_sdi_rx <= 12'h000;
        end else begin
            m_rise   <= m_rise + 1;
            m_sdi_rx <= {m_sdi_rx[10:0], adc_sdi};
        end
    end

    always_comb m_sh = model_word << m_rise;
    assign adc_sdo = m_sh[11];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. Observes cycles 1..141 of the frame.
    task automatic run_frame(input logic [2:0] ch, input logic uni, input logic [11:0] word,
                             input logic [11:0] exp_sdi, input logic hold, input logic exp_rv,
                             input logic [2:0] exp_ch, input logic [11:0] exp_data,
                             input int rst_at);
        int cv_cnt = 0, cv_first = 0, cv_last = 0;
        int rv_cnt = 0, rv_cyc = 0, rdy_first = 0;
        logic [11:0] rv_data = 12'h000;
        logic [2:0]  rv_ch = 3'd0;
        model_word = word;
        req_ch     = ch;
        req_uni    = uni;
        req_valid  = 1'b1;
        check("ready_at_request", req_ready, 1'b1);
        for (int n = 1; n <= 141; n++) begin
            @(negedge clk);
            if (!hold || n == 140) req_valid = 1'b0;
            if (rst_at != 0 && n == rst_at) begin
                check("sck_high_before_reset", adc_sck, 1'b1);
                reset = 1'b1;
                #1;
                check("rst_convst", adc_convst, 1'b0);
                check("rst_sck", adc_sck, 1'b0);
                check("rst_sdi", adc_sdi, 1'b0);
                check("rst_res_valid", res_valid, 1'b0);
                check("rst_ready", req_ready, 1'b1);
                repeat (3) @(negedge clk);
                reset = 1'b0;
                break;
            end
            if (adc_convst) begin
                cv_cnt++;
                if (cv_first == 0) cv_first = n;
                cv_last = n;
            end
            if (res_valid) begin
                rv_cnt++;
                rv_cyc  = n;
                rv_data = res_data;
                rv_ch   = res_ch;
            end
            if (req_ready && rdy_first == 0) rdy_first = n;
        end
        if (rst_at == 0) begin
            check("convst_cycles", cv_cnt, 80);
            check("convst_first", cv_first, 1);
            check("convst_last", cv_last, 80);
            check("sck_rises", m_rise, 12);
            check("sdi_word", m_sdi_rx, exp_sdi);
            check("ready_return", rdy_first, 141);
            check("res_valid_count", rv_cnt, {31'd0, exp_rv});
            if (exp_rv) begin
                check("res_valid_cycle", rv_cyc, 129);
                check("res_data", rv_data, exp_data);
                check("res_ch", rv_ch, exp_ch);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_ch    = 3'd0;
        req_uni   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", req_ready, 1'b1);
        check("reset_convst", adc_convst, 1'b0);
        check("reset_sck", adc_sck, 1'b0);
        check("reset_sdi", adc_sdi, 1'b0);
        check("reset_res_valid", res_valid, 1'b0);
        check("reset_res_data", res_data, 12'h000);
        check("reset_res_ch", res_ch, 3'd0);
        reset = 1'b0;
        @(negedge clk);

        // Dummy first frame, then pipelined results tagged with the previous channel.
        run_frame(3'd3, 1'b1, 12'h123, 12'hD80, 1'b0, 1'b0, 3'd0, 12'h000, 0);
        check("res_data_held_dummy", res_data, 12'h000);
        run_frame(3'd5, 1'b1, 12'hA5C, 12'hE80, 1'b0, 1'b1, 3'd3, 12'hA5C, 0);
        run_frame(3'd0, 1'b0, 12'h3C1, 12'h800, 1'b1, 1'b1, 3'd5, 12'h3C1, 0);
        run_frame(3'd7, 1'b1, 12'hFFF, 12'hF80, 1'b0, 1'b1, 3'd0, 12'hFFF, 0);
        run_frame(3'd6, 1'b0, 12'h000, 12'hB00, 1'b0, 1'b1, 3'd7, 12'h000, 0);
        check("res_data_held", res_data, 12'h000);

        // Reset during bit 7 high phase; next frame is a dummy again.
        run_frame(3'd1, 1'b1, 12'h555, 12'h000, 1'b0, 1'b0, 3'd0, 12'h000, 112);
        run_frame(3'd2, 1'b0, 12'hABC, 12'h900, 1'b0, 1'b0, 3'd0, 12'h000, 0);
        run_frame(3'd4, 1'b1, 12'h0F0, 12'hA80, 1'b0, 1'b1, 3'd2, 12'h0F0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
